// File: rtl/adder_accumulator.sv
// ---------------------------------------------------------------------------
// adder_accumulator
//   Streams 5-bit operands into an accumulator through one combinational
//   5-bit adder, then presents the batch sum, operand count and a sticky
//   unsigned-wrap flag over a result handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_ACCUM | accepting operands (in_ready=1), accumulating into acc_q
//   ST_DONE  | holding the batch result (out_valid=1) until out_ready
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand
//   in_data    5-bit unsigned operand
//   in_last    final operand of the batch (qualified by in_valid)
//   out_valid  batch result valid
//   out_ready  consumer accepts the result
//   out_sum    accumulated sum mod 32
//   out_count  operands accepted in the batch
//   out_wrap   at least one addition wrapped past 31
// ---------------------------------------------------------------------------

// 5-bit combinational adder, sum modulo 32, no carries.
module adder (
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic [4:0] z
);
    assign z = x + y;
endmodule

module adder_accumulator #(
    parameter int N_OPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_sum,
    output logic [3:0] out_count,
    output logic       out_wrap
);

    localparam logic [3:0] LAST_CNT = 4'(N_OPS - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wrap_q, wrap_d;
    logic [4:0] sum_z;

    adder u_adder (
        .x (acc_q),
        .y (in_data),
        .z (sum_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d  = sum_z;
                    cnt_d  = cnt_q + 4'd1;
                    // A mod-32 result smaller than the old accumulator means the add wrapped.
                    wrap_d = wrap_q | (sum_z < acc_q);
                    if (in_last || (cnt_q == LAST_CNT)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Handshake outputs come straight from the state register: no input-to-output path.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_wrap  = wrap_q;

endmodule

// File: tb/tb_adder_accumulator.sv
module tb_adder_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic [3:0] out_count;
    logic       out_wrap;

    int n_compared   = 0;
    int n_mismatched = 0;

    adder_accumulator #(.N_OPS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_wrap  (out_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [4:0] s,
                              input logic [3:0] c, input logic w);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_wrap"}, out_wrap, w);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_wrap", out_wrap, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // batch ends on count: 3+5+7+9 = 24
        beat(5'd3, 1'b0);
        beat(5'd5, 1'b0);
        beat(5'd7, 1'b0);
        chk("t1_mid_ready", in_ready, 1);
        chk("t1_mid_valid", out_valid, 0);
        chk("t1_mid_sum", out_sum, 15);
        chk("t1_mid_count", out_count, 3);
        beat(5'd9, 1'b0);
        chk_result("t1", 5'd24, 4'd4, 1'b0);
        // an extra beat offered during DONE must not be absorbed
        in_valid = 1'b1; in_data = 5'd1;
        step();
        in_valid = 1'b0;
        chk_result("t1_hold", 5'd24, 4'd4, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_rel_ready", in_ready, 1);
        chk("t1_rel_valid", out_valid, 0);
        chk("t1_rel_sum", out_sum, 0);
        chk("t1_rel_count", out_count, 0);

        // 20+20 = 40 -> 8 with wrap
        beat(5'd20, 1'b0);
        beat(5'd20, 1'b1);
        chk_result("t2", 5'd8, 4'd2, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_rel_ready", in_ready, 1);

        // single beat, consumer stalls three cycles with in_valid asserted
        beat(5'd31, 1'b1);
        chk_result("t3_first", 5'd31, 4'd1, 1'b0);
        in_valid = 1'b1; in_data = 5'd5; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_result("t3_stall", 5'd31, 4'd1, 1'b0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t3_rel_ready", in_ready, 1);
        chk("t3_rel_valid", out_valid, 0);

        // back-to-back batches, out_ready tied high
        beat(5'd1, 1'b0);
        beat(5'd2, 1'b1);
        chk_result("t4a", 5'd3, 4'd2, 1'b0);
        step();
        chk("t4_bubble_ready", in_ready, 1);
        chk("t4_clr_sum", out_sum, 0);
        chk("t4_clr_count", out_count, 0);
        chk("t4_clr_wrap", out_wrap, 0);
        beat(5'd30, 1'b0);
        beat(5'd3, 1'b1);
        chk_result("t4b", 5'd1, 4'd2, 1'b1);
        step();
        chk("t4b_rel_ready", in_ready, 1);
        out_ready = 1'b0;

        // reset in the middle of a batch
        beat(5'd10, 1'b0);
        beat(5'd10, 1'b0);
        chk("t5_pre_sum", out_sum, 20);
        chk("t5_pre_count", out_count, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_sum", out_sum, 0);
        chk("t5_rst_count", out_count, 0);
        #2;
        rst_n = 1'b1;
        step();
        chk("t5_post_ready", in_ready, 1);
        beat(5'd4, 1'b1);
        chk_result("t5", 5'd4, 4'd1, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // gapped valid; in_last on an idle cycle is ignored
        beat(5'd6, 1'b0);
        in_valid = 1'b0; in_data = 5'd9; in_last = 1'b1;
        step();
        in_last = 1'b0;
        chk("t6_gap_valid", out_valid, 0);
        chk("t6_gap_count", out_count, 1);
        beat(5'd6, 1'b1);
        chk_result("t6", 5'd12, 4'd2, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_rel_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
